fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 47 ++++
 rtl/fifo_mem.sv | 37 +++
 rtl/fifo_sync_param.sv | 140 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO.
//   - ptr_w()/cnt_w(): pointer and occupancy widths derived from DEPTH.
//   - ptr_t/cnt_t:     concrete types for the default DEPTH of 16.
//   - fifo_status_t:   bundled status for consumers that carry flags together.
//   - is_pow2()/af_in_range()/ae_in_range(): elaboration-time parameter checks.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DEF_DEPTH = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent DEPTH itself (full).
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEF_DEPTH):0]   cnt_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit af_in_range(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_in_range(input int ae, input int depth);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. Contents are not reset.
// Ports:
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [ptr_w(DEPTH)-1:0]        i_waddr,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]        i_raddr,
  output logic [WIDTH-1:0]               o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised synchronous FIFO with push/pop handshake, registered occupancy
// count, almost-full/almost-empty thresholds and sticky error flags.
// FWFT=0: data_out is a register loaded on each accepted pop.
// FWFT=1: data_out shows the head word whenever the FIFO is not empty, else 0.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, data_in - write request and data
//   pop           - read request
//   data_out      - read data
//   full, empty, almost_full, almost_empty - status derived from count
//   count         - occupancy 0..DEPTH
//   overflow      - sticky: push attempted while full without a same-cycle pop
//   underflow     - sticky: pop attempted while empty
//   clr_err       - synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   pop,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (!af_in_range(AF_LEVEL, DEPTH)) begin : g_chk_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (!ae_in_range(AE_LEVEL, DEPTH)) begin : g_chk_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [WIDTH-1:0] w_rd_data;

  // Flags come from the registered count only, never from pointer compare.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  // There is no bypass: a pop on an empty FIFO is rejected even with a push.
  assign w_pop_ok  = pop & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pop_ok);
  assign w_ovf_evt = push & ~w_push_ok;
  assign w_unf_evt = pop & ~w_pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
      // A new error wins over a same-cycle clear.
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_unf_evt)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] r_data_out;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_out <= '0;
      end else if (w_pop_ok) begin
        r_data_out <= w_rd_data;
      end
    end
    assign data_out = r_data_out;
  end else begin : g_fwft_read
    assign data_out = w_empty ? '0 : w_rd_data;
  end

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic       clk;
  logic       rst_n;

  // Registered-read instance
  logic       push0, pop0, clr0;
  logic [7:0] din0, data_out0;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [2:0] count0;

  // FWFT instance
  logic       push1, pop1, clr1;
  logic [7:0] din1, data_out1;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] count1;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench model
  int         m_count;
  logic       m_ovf, m_unf;
  logic [7:0] m_dout;
  logic [7:0] sb[$];

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .data_in(din0), .pop(pop0),
    .data_out(data_out0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0),
    .clr_err(clr0)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .data_in(din1), .pop(pop1),
    .data_out(data_out1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
    sb.delete();
  endtask

  // Drive one cycle on dut0 and advance the model; returns at posedge+1.
  task automatic step(input logic p, input logic [7:0] d, input logic q, input logic c);
    logic pop_ok, push_ok;
    pop_ok  = q && (m_count != 0);
    push_ok = p && ((m_count != 4) || pop_ok);
    if (pop_ok) m_dout = sb.pop_front();
    if (push_ok) sb.push_back(d);
    if (p && !push_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (q && !pop_ok)  m_unf = 1'b1; else if (c) m_unf = 1'b0;
    m_count = m_count + int'(push_ok) - int'(pop_ok);
    push0 = p; din0 = d; pop0 = q; clr0 = c;
    @(posedge clk); #1;
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if (empty0 !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty0); end
    n_cmp++; if (count0 !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count0); end
    n_cmp++; if (data_out0 !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", data_out0); end
    n_cmp++; if ({full0, af0, ae0} !== 3'b001) begin n_bad++; $display("FAIL reset_flags: got %b want 001", {full0, af0, ae0}); end
    n_cmp++; if ({ovf0, unf0} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", {ovf0, unf0}); end
    n_cmp++; if ({empty1, data_out1} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL reset_fwft: got %b/%h want 1/00", empty1, data_out1); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'd9, 8'd45, 8'd10, 8'd7};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0);
      n_cmp++; if (count0 !== 3'(m_count)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count0, m_count); end
      n_cmp++; if (af0 !== (m_count >= 3)) begin n_bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, af0, (m_count >= 3)); end
      n_cmp++; if (ae0 !== (m_count <= 1)) begin n_bad++; $display("FAIL fill_ae[%0d]: got %b want %b", i, ae0, (m_count <= 1)); end
    end
    n_cmp++; if ({full0, empty0} !== 2'b10) begin n_bad++; $display("FAIL fill_full: got %b want 10", {full0, empty0}); end
    n_cmp++; if (data_out0 !== 8'h00) begin n_bad++; $display("FAIL fill_dout_hold: got %h want 00", data_out0); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, data_out0, m_dout); end
    end
    n_cmp++; if ({empty0, count0} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL drain_empty: got %b/%0d want 1/0", empty0, count0); end
  endtask

  task automatic test_overflow_wrap();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b0, 1'b0);
    n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    n_cmp++; if (count0 !== 3'(m_count)) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", count0, m_count); end
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", k, data_out0, m_dout); end
      end else begin
        step(1'b1, 8'(20 + k), 1'b0, 1'b0);
      end
    end
    while (m_count > 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL wrap_drain: got %0d want %0d", data_out0, m_dout); end
    end
    n_cmp++; if (ovf0 !== m_ovf) begin n_bad++; $display("FAIL ovf_sticky: got %b want %b", ovf0, m_ovf); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(50 + i), 1'b0, 1'b0);
    step(1'b1, 8'd60, 1'b1, 1'b0);
    n_cmp++; if (count0 !== 3'd4) begin n_bad++; $display("FAIL full_pp_count: got %0d want 4", count0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovf: got %b want 0", ovf0); end
    n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL full_pp_data: got %0d want %0d", data_out0, m_dout); end
    while (m_count > 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL full_pp_drain: got %0d want %0d", data_out0, m_dout); end
    end
    step(1'b1, 8'd5, 1'b1, 1'b0);
    n_cmp++; if (unf0 !== 1'b1) begin n_bad++; $display("FAIL empty_pp_unf: got %b want 1", unf0); end
    n_cmp++; if (count0 !== 3'd1) begin n_bad++; $display("FAIL empty_pp_count: got %0d want 1", count0); end
    n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL empty_pp_hold: got %0d want %0d", data_out0, m_dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (data_out0 !== 8'd5) begin n_bad++; $display("FAIL empty_pp_later: got %0d want 5", data_out0); end
    // clear coincident with a fresh underflow: the new error wins
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (unf0 !== m_unf) begin n_bad++; $display("FAIL clr_prio: got %b want %b", unf0, m_unf); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if ({ovf0, unf0} !== 2'b00) begin n_bad++; $display("FAIL clr_both: got %b want 00", {ovf0, unf0}); end
  endtask

  task automatic test_fwft();
    push1 = 1'b1; din1 = 8'h3C;
    @(posedge clk); #1;
    push1 = 1'b0; din1 = 8'h00;
    n_cmp++; if (data_out1 !== 8'h3C) begin n_bad++; $display("FAIL fwft_data: got %h want 3c", data_out1); end
    n_cmp++; if ({empty1, count1} !== {1'b0, 3'd1}) begin n_bad++; $display("FAIL fwft_empty: got %b/%0d want 0/1", empty1, count1); end
    pop1 = 1'b1;
    @(posedge clk); #1;
    pop1 = 1'b0;
    n_cmp++; if ({empty1, data_out1} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL fwft_pop: got %b/%h want 1/00", empty1, data_out1); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(71 + i), 1'b0, 1'b0);
    n_cmp++; if (count0 !== 3'd3) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 3", count0); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({count0, empty0, full0, af0, ae0} !== {3'd0, 4'b1001}) begin n_bad++; $display("FAIL mid_rst_state: got %0d/%b want 0/1001", count0, {empty0, full0, af0, ae0}); end
    n_cmp++; if ({data_out0, ovf0, unf0} !== {8'h00, 2'b00}) begin n_bad++; $display("FAIL mid_rst_data: got %h/%b want 00/00", data_out0, {ovf0, unf0}); end
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'd88, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (data_out0 !== m_dout) begin n_bad++; $display("FAIL mid_after: got %0d want %0d", data_out0, m_dout); end
    n_cmp++; if (empty0 !== 1'b1) begin n_bad++; $display("FAIL mid_after_empty: got %b want 1", empty0); end
  endtask

  initial begin
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; din0 = 8'h00;
    push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; din1 = 8'h00;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow_wrap();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
